csa_ts_repack: RTL and testbench
================================

# csa_ts_repack

Downstream stage of the CSA descramble core. Merges clear TS header/adaptation bytes, which bypass the core, with descrambled payload bytes (`db`/`db_valid`) into one 188-byte transport packet stream. Clears `transport_scrambling_control` in header byte 3. Buffers the result in a 32-entry FIFO with ready/valid output toward the TS output mux.

## Interface
- `PKT_LEN`, 188, transport packet length in bytes.
- `FIFO_DEPTH`, 32, output FIFO entries (power of two).
- `clk`  in  1  system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `hdr_byte`  in  [0:7]  clear header/adaptation byte from the TS parser; bit 0 = MSB.
- `hdr_valid`  in  1  `hdr_byte` qualifier, one byte per cycle.
- `db`  in  [0:7]  descrambled payload byte from the descramble core.
- `db_valid`  in  1  `db` qualifier.
- `out_data`  out  [0:7]  packet byte.
- `out_sop`  out  1  `out_data` is byte 0 (0x47).
- `out_eop`  out  1  `out_data` is byte `PKT_LEN`-1.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the byte when `out_valid` & `out_ready`.
- `err_len`  out  1  one-cycle pulse on a short or long packet.
- `ovf`  out  1  sticky: a byte was dropped because the FIFO was full.
- `clr_err`  in  1  synchronous clear of `ovf`.

## Operation
- Packet FSM states:
  - IDLE: hunt for sync.
    - `hdr_valid` with `hdr_byte`==0x47: write the byte with sop=1, cnt<=1, go to HDR.
    - Any other `hdr_byte`: dropped silently.
    - `db_valid`: byte dropped, `err_len` pulses (long packet).
  - HDR:
    - `hdr_valid`: write the byte, cnt++.
    - At cnt==3, write {2'b00, `hdr_byte`[2:7]}, i.e. clear the TSC bits.
    - If both valids are high, take `hdr_valid`; `db` is dropped, no error.
    - `db_valid` alone: write `db`, cnt++, go to PAY.
  - PAY:
    - `db_valid`: write `db`, cnt++.
    - `hdr_valid` with 0x47: short packet. `err_len` pulses, the partial packet gets no eop, and the new byte is written with sop=1, cnt<=1, state HDR.
    - `hdr_valid` with any other value: dropped, `err_len` pulses.
  - Completion rule, HDR or PAY: the byte written at cnt==`PKT_LEN`-1 carries eop=1, then cnt<=0 and state IDLE.
    - This covers a packet with no payload (all 188 header bytes), which completes in HDR.
- `cnt` is 8 bits, range 0..187, and never wraps past 187.
- FIFO:
  - 10-bit entries {data, sop, eop}.
  - First-word-fall-through; `out_valid` = not empty.
  - Pop on `out_valid` & `out_ready`.
  - Occupancy counter is 6 bits.
  - A write while full is dropped and sets `ovf`, even if a pop occurs in the same cycle.
  - The FSM still advances `cnt` for a dropped byte, so packet framing stays intact.
- `ovf`:
  - `clr_err` clears it.
  - If set and clear happen in the same cycle, the set wins.
- `out_sop`/`out_eop`/`out_data` are meaningful only while `out_valid`=1.

## Timing
- Reset (async assert, sync release):
  - All outputs are 0: `out_data`=0x00, `out_valid`=0, `out_sop`=0, `out_eop`=0, `err_len`=0, `ovf`=0.
  - FSM is in IDLE, cnt=0, FIFO empty.
- Reset mid-packet discards the FIFO contents and the partial packet; no eop is emitted.
- Latency: a byte accepted at edge N is presented with `out_valid`=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: one write and one pop per cycle; a continuous full-rate stream with `out_ready`=1 never fills the FIFO.
- `err_len` is registered and asserts the cycle after the offending input.
- `out_ready` may toggle at any time.
- Outputs hold stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Nominal packet:
  - Stimulus: 4 header bytes 47 1F FF D5, then 184 `db` bytes 00..B7, with `out_ready`=1.
  - Required response: 188 bytes out; byte 3 = 0x15; sop on byte 0; eop on byte 187 (0xB7); `err_len`=0.
- Adaptation field:
  - Stimulus: 12 header bytes with byte 3 = 0xF0, then 176 `db` bytes.
  - Required response: byte 3 out = 0x30; eop on the 188th byte.
- Short packet:
  - Stimulus: 4 header + 100 `db` bytes, then `hdr_valid` 0x47.
  - Required response: `err_len` pulses once; the 104 bytes have no eop; the next byte out has sop=1 and value 0x47.
- Sync hunt and long packet:
  - Stimulus: `hdr_byte` 0x12 in IDLE, then one extra `db` after a completed packet.
  - Required response: 0x12 dropped with no error; the extra byte dropped and `err_len` pulses.
- Backpressure and overflow:
  - Stimulus: `out_ready`=0 for 40 input bytes.
  - Required response: `out_valid`=1 and 32 bytes buffered; `ovf`=1; the 8 later bytes are lost while framing is kept (next packet still gets sop correctly).
  - Stimulus: `clr_err` pulse.
  - Required response: `ovf` returns to 0.
- Reset mid-packet:
  - Stimulus: `nrst` low for 1 cycle during PAY at cnt=50.
  - Required response: `out_valid` drops to 0 immediately; the next 0x47 starts a clean packet.

Source files
------------

// File: rtl/csa_ts_repack.sv
`default_nettype none
// ============================================================================
//  Module      : csa_ts_repack
//  Description : Merges clear TS header/adaptation bytes with descrambled
//                payload bytes into a single 188-byte transport packet
//                stream, clears transport_scrambling_control in header
//                byte 3 and buffers the result in a first-word-fall-through
//                FIFO with a ready/valid output.
//  Ports       : clk, nrst         clock, async active-low reset
//                hdr_byte/valid    clear header/adaptation byte (bit 0 = MSB)
//                db/db_valid       descrambled payload byte
//                out_data/sop/eop  packet byte and framing flags
//                out_valid/ready   output handshake (valid = FIFO not empty)
//                err_len           one-cycle pulse on short/long packet
//                ovf, clr_err      sticky FIFO-overflow flag and its clear
//  Revision    : 1.0  initial release
// ============================================================================
module csa_ts_repack #(
    parameter int PKT_LEN    = 188,
    parameter int FIFO_DEPTH = 32
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [0:7] hdr_byte,
    input  logic       hdr_valid,
    input  logic [0:7] db,
    input  logic       db_valid,
    output logic [0:7] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_len,
    output logic       ovf,
    input  logic       clr_err
);

    localparam int         AW     = $clog2(FIFO_DEPTH);
    localparam logic [7:0] c_last = 8'(PKT_LEN - 1);
    localparam logic [7:0] c_sync = 8'h47;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic        w_wr_en;
    logic [0:7]  w_wr_data;
    logic        w_wr_sop;
    logic        w_wr_eop;
    logic        w_adv;
    logic        w_err;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_err;
    logic          r_ovf;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [9:0]    w_head;

    // ------------------------------------------------------------------
    // Packet framing FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_wr_data   = hdr_byte;
        w_wr_sop    = 1'b0;
        w_wr_eop    = 1'b0;
        w_adv       = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (hdr_valid) begin
                    // Anything but the sync byte is silently skipped while hunting
                    if (hdr_byte == c_sync) begin
                        w_wr_en     = 1'b1;
                        w_wr_sop    = 1'b1;
                        w_cnt_nxt   = 8'd1;
                        w_state_nxt = ST_HDR;
                    end
                end else if (db_valid) begin
                    w_err = 1'b1;
                end
            end
            ST_HDR: begin
                if (hdr_valid) begin
                    // Header wins over a simultaneous payload byte
                    w_wr_en   = 1'b1;
                    w_adv     = 1'b1;
                    w_wr_data = (r_cnt == 8'd3) ? {2'b00, hdr_byte[2:7]} : hdr_byte;
                end else if (db_valid) begin
                    w_wr_en     = 1'b1;
                    w_adv       = 1'b1;
                    w_wr_data   = db;
                    w_state_nxt = ST_PAY;
                end
            end
            ST_PAY: begin
                if (hdr_valid && hdr_byte == c_sync) begin
                    // Short packet: abandon the partial one and restart framing
                    w_err       = 1'b1;
                    w_wr_en     = 1'b1;
                    w_wr_sop    = 1'b1;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = ST_HDR;
                end else begin
                    if (db_valid) begin
                        w_wr_en   = 1'b1;
                        w_adv     = 1'b1;
                        w_wr_data = db;
                    end
                    if (hdr_valid) begin
                        w_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase

        // Completion: the byte at the last index closes the packet. cnt keeps
        // advancing even when the FIFO drops the byte, so framing survives.
        if (w_adv) begin
            if (r_cnt == c_last) begin
                w_wr_eop    = 1'b1;
                w_cnt_nxt   = 8'd0;
                w_state_nxt = ST_IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO, first-word-fall-through
    // ------------------------------------------------------------------
    assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle does not make room for a write into a full FIFO
    assign w_push = w_wr_en && !w_full;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_wr_data, w_wr_sop, w_wr_eop};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_err <= w_err;
            // Set has priority over clear
            if (w_wr_en && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Outputs are forced to zero while empty so reset and idle read back as 0
    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_head[9:2] : 8'h00;
    assign out_sop   = out_valid & w_head[1];
    assign out_eop   = out_valid & w_head[0];
    assign err_len   = r_err;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csa_ts_repack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_ts_repack
//  Description : Self-checking bench for csa_ts_repack. Stimulus pushes the
//                expected {data, sop, eop} of every byte that must appear on
//                the output into a queue; an independent monitor pops and
//                compares on each accepted output byte.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csa_ts_repack;

    logic       clk;
    logic       nrst;
    logic [0:7] hdr_byte;
    logic       hdr_valid;
    logic [0:7] db;
    logic       db_valid;
    logic [0:7] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_valid;
    logic       out_ready;
    logic       err_len;
    logic       ovf;
    logic       clr_err;

    int         n_tests;
    int         n_fail;
    int         n_err;
    logic [9:0] sb[$];

    csa_ts_repack #(.PKT_LEN(188), .FIFO_DEPTH(32)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .hdr_byte  (hdr_byte),
        .hdr_valid (hdr_valid),
        .db        (db),
        .db_valid  (db_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_len   (err_len),
        .ovf       (ovf),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            logic [9:0] got;
            got = {out_data, out_sop, out_eop};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_byte: unexpected output %h (sop=%0b eop=%0b), none required",
                         out_data, out_sop, out_eop);
            end else begin
                logic [9:0] exp_e;
                exp_e = sb.pop_front();
                if (got !== exp_e) begin
                    n_fail++;
                    $display("FAIL out_byte: got data=%h sop=%0b eop=%0b, required data=%h sop=%0b eop=%0b",
                             got[9:2], got[1], got[0], exp_e[9:2], exp_e[1], exp_e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (nrst && err_len) n_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic hb(input logic [7:0] b);
        hdr_valid = 1'b1;
        hdr_byte  = b;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
    endtask

    task automatic pb(input logic [7:0] b);
        db_valid = 1'b1;
        db       = b;
        @(posedge clk); #1;
        db_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Send bytes [from, to) of a packet with nh header bytes. Header byte k
    // is 0x47 at k=0, b3 at k=3 and k otherwise; payload byte k is k-nh.
    task automatic send_range(input int nh, input logic [7:0] b3,
                              input int from, input int to, input bit push);
        for (int k = from; k < to; k++) begin
            logic [7:0] v;
            logic [7:0] e;
            if (k < nh) begin
                v = (k == 0) ? 8'h47 : (k == 3) ? b3 : k[7:0];
                e = (k == 3) ? (b3 & 8'h3F) : v;
            end else begin
                int p;
                p = k - nh;
                v = p[7:0];
                e = v;
            end
            if (push) sb.push_back({e, (k == 0), (k == 187)});
            if (k < nh) hb(v);
            else        pb(v);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        chk(name, {31'd0, (t >= 1000)}, 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        n_err     = 0;
        nrst      = 1'b0;
        hdr_byte  = 8'h00;
        hdr_valid = 1'b0;
        db        = 8'h00;
        db_valid  = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;

        // Reset state
        idle(2);
        chk("rst_out_data",  {24'd0, out_data}, 32'h00);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sop",   {31'd0, out_sop},   32'd0);
        chk("rst_out_eop",   {31'd0, out_eop},   32'd0);
        chk("rst_err_len",   {31'd0, err_len},   32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        nrst = 1'b1;
        idle(1);

        // Nominal packet: 47 1F FF D5 + payload 00..B7
        sb.push_back({8'h47, 1'b1, 1'b0});
        hb(8'h47);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_sop",   {31'd0, out_sop},   32'd1);
        sb.push_back({8'h1F, 1'b0, 1'b0}); hb(8'h1F);
        sb.push_back({8'hFF, 1'b0, 1'b0}); hb(8'hFF);
        sb.push_back({8'h15, 1'b0, 1'b0}); hb(8'hD5);
        send_range(4, 8'hD5, 4, 188, 1'b1);
        wait_drain("nominal_drain");
        chk("nominal_err", n_err, 0);

        // Adaptation field: 12 header bytes, byte 3 = F0 -> 30
        send_range(12, 8'hF0, 0, 188, 1'b1);
        wait_drain("adapt_drain");
        chk("adapt_err", n_err, 0);

        // Short packet: 104 bytes without eop, then a new packet
        send_range(4, 8'h90, 0, 104, 1'b1);
        send_range(4, 8'h83, 0, 188, 1'b1);
        wait_drain("short_drain");
        chk("short_err", n_err, 1);

        // Sync hunt: non-sync header byte dropped silently
        hb(8'h12);
        idle(3);
        chk("hunt_err",   n_err, 1);
        chk("hunt_valid", {31'd0, out_valid}, 32'd0);

        // Long packet: stray payload byte in IDLE
        pb(8'h55);
        idle(3);
        chk("long_err",   n_err, 2);
        chk("long_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: 40 bytes with out_ready=0, first 32 buffered
        out_ready = 1'b0;
        send_range(4, 8'hC3, 0, 32, 1'b1);
        send_range(4, 8'hC3, 32, 40, 1'b0);
        idle(2);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_ovf",   {31'd0, ovf},       32'd1);
        chk("bp_head",  {24'd0, out_data},  32'h47);
        chk("bp_sop",   {31'd0, out_sop},   32'd1);
        out_ready = 1'b1;
        idle(5);
        send_range(4, 8'hC3, 40, 188, 1'b1);
        wait_drain("bp_drain");
        chk("bp_ovf_sticky", {31'd0, ovf}, 32'd1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("clr_ovf", {31'd0, ovf}, 32'd0);

        // Next packet after overflow still frames with sop; then reset at cnt=50
        out_ready = 1'b0;
        send_range(4, 8'h00, 0, 50, 1'b0);
        chk("pre_rst_head", {24'd0, out_data}, 32'h47);
        chk("pre_rst_sop",  {31'd0, out_sop},  32'd1);
        nrst = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ovf",   {31'd0, ovf},       32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send_range(4, 8'hC0, 0, 188, 1'b1);
        wait_drain("post_rst_drain");
        chk("final_err", n_err, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
